// File: rtl/fetch_pkg.sv
// Shared types and defaults for the minicpu instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDiscard
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {addr, data}, head word visible on the output.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W-1:0]  rd_q;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !(reset || flush)) begin
            addr_mem[wr_q] <= push_addr;
            data_mem[wr_q] <= push_data;
        end
    end

    // Empty FIFO presents zeros rather than stale storage.
    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_addr  = head_valid ? addr_mem[rd_q] : '0;
    assign head_data  = head_valid ? data_mem[rd_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack memory reads into a prefetch FIFO, drives PC inc/load.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_flushed
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    fetch_state_t     state_q;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             room_now;
    logic             room_after;

    assign push         = (state_q == StReq) && mem_ack && !redirect && !reset;
    assign pop          = instr_valid && instr_ready && !reset;
    assign pc_inc       = push;
    assign pc_load      = redirect && !reset;
    assign pc_load_addr = redirect_pc;
    assign room_now     = (count < CNT_FULL);
    // A slot survives this push if a pop frees one or at least two are free now.
    assign room_after   = pop || (count < CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redirect) begin
                        state_q  <= StReq;
                        mem_req  <= 1'b1;
                        mem_addr <= redirect_pc;
                    end else if (room_now) begin
                        state_q  <= StReq;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_value;
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        if (redirect) begin
                            mem_addr <= redirect_pc;
                        end else if (room_after) begin
                            mem_addr <= pc_value + 1'b1;
                        end else begin
                            state_q <= StIdle;
                            mem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        // The bus forbids withdrawing a request; wait it out.
                        state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (mem_ack) begin
                        state_q  <= StReq;
                        mem_addr <= redirect ? redirect_pc : pc_value;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_addr  (mem_addr),
        .push_data  (mem_rdata),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (instr_valid),
        .head_addr  (instr_pc),
        .head_data  (instr)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push)     perf_fetched <= perf_fetched + 16'd1;
            if (redirect) perf_flushed <= perf_flushed + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the minicpu. Consumes the program counter value, issues single-word read requests to instruction memory over a req/ack handshake and buffers returned words in a small prefetch FIFO. Presents instructions to the decoder with valid/ready. Drives the PC's `inc`/`load` controls, so the PC advances only when a fetch completes or a branch redirects it.

## Interface
- `ADDR_W`, 16, instruction address width; matches PC width.
- `DATA_W`, 16, instruction word width.
- `DEPTH`, 2, prefetch FIFO entries; power of two, ≥2.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `pc_value`  in  ADDR_W  current PC output.
- `pc_inc`  out  1  PC increment request; combinational.
- `pc_load`  out  1  PC load request; combinational.
- `pc_load_addr`  out  ADDR_W  value for PC load; equals `redirect_pc`.
- `mem_req`  out  1  read request; registered.
- `mem_addr`  out  ADDR_W  read address; registered, stable while `mem_req`=1.
- `mem_ack`  in  1  read complete; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  DATA_W  read data.
- `instr_valid`  out  1  FIFO head valid.
- `instr_ready`  in  1  decoder accepts head.
- `instr`  out  DATA_W  head instruction word.
- `instr_pc`  out  ADDR_W  address the head word was fetched from.
- `redirect`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  ADDR_W  target address.

## Operation
- Reset: `mem_req`=0, `mem_addr`=0, FIFO empty (`instr_valid`=0, `instr`=0, `instr_pc`=0), state IDLE. `pc_inc` and `pc_load` are 0 while `reset`=1.
- FSM states: IDLE, REQ, DISCARD.
- IDLE→REQ when the FIFO has a free slot and `redirect`=0. On entry, register `mem_req`=1 and `mem_addr`=`pc_value`.
- REQ, `mem_ack`=1, no redirect: push {`mem_addr`, `mem_rdata`} and assert `pc_inc` this cycle. If a slot will still be free after this push (counting a same-cycle pop), stay in REQ with `mem_addr`=`pc_value`+1 (back-to-back). Otherwise drop `mem_req` and go to IDLE.
- REQ, `mem_ack`=0: hold `mem_req` and `mem_addr` unchanged.
- `redirect`=1, any state: assert `pc_load`; flush FIFO (`instr_valid`=0 next cycle). A redirect with a same-cycle pop flushes, and the pop has no other effect.
  - In REQ with no ack this cycle: go to DISCARD. `mem_req` and `mem_addr` stay held, because the bus forbids withdrawing a request.
  - In REQ with ack this cycle: data is dropped and `pc_inc`=0. Next state is REQ with `mem_addr`=`redirect_pc`.
  - In IDLE: go to REQ with `mem_addr`=`redirect_pc`.
- DISCARD: on `mem_ack`, drop data and issue `mem_addr`=`pc_value` (the redirected PC) in REQ. A further `redirect` in DISCARD only re-asserts `pc_load`.
- `pc_inc` and `pc_load` are never both 1. Load wins.
- Pop when `instr_valid` && `instr_ready`. Push and pop in the same cycle are both honoured.
- Address arithmetic is modulo 2^ADDR_W: fetch from 0xFFFF is followed by fetch from 0x0000.

## Timing
- First `mem_req` is high in the 2nd cycle after `reset` falls (IDLE decision, then registered request).
- Ack in cycle N → `instr_valid` high in cycle N+1; PC shows +1 in cycle N+1.
- With zero-wait memory (`mem_ack` tied high) and a decoder always ready: one instruction per cycle, `mem_req` continuously high.
- Redirect in cycle N, no request in flight: `mem_addr`=`redirect_pc` with `mem_req`=1 in cycle N+1. First target instruction is valid no earlier than N+2.
- Reset mid-request: outputs go to reset values at the next edge. Memory must tolerate a dropped request.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetched` (16 b, +1 per FIFO push) and `perf_flushed` (16 b, +1 per cycle with `redirect`=1). Both counters wrap and are cleared by `reset`.
- Not defined: these ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (IDLE/REQ/DISCARD);
  - the `ADDR_W`/`DATA_W` defaults;
  - the FIFO entry struct {addr, data}.
- Sub-module `fetch_fifo`: synchronous FIFO, `DEPTH` entries, with push/pop/flush, a count output and first-word visible on the output.

## Test plan
- Reset release, PC=0x0000, ack each request after 1 wait cycle, `instr_ready`=1 → words at 0x0000, 0x0001, 0x0002 emitted in order with matching `instr_pc`, and exactly one `pc_inc` pulse per ack.
- `mem_ack` tied 1, `instr_ready`=0 → exactly `DEPTH`=2 fetches, then `mem_req`=0. Raising ready resumes fetching with no lost or duplicated addresses.
- `redirect`=1 to 0x0100 while a request to 0x0005 waits 3 cycles for ack → `mem_addr` held at 0x0005 until ack, data discarded, next `mem_addr`=0x0100, and no 0x0005 word reaches the decoder.
- `redirect` to 0x0040 in the same cycle as an ack and a pop → FIFO empty next cycle, `pc_inc`=0, `pc_load`=1, and next `mem_addr`=0x0040.
- PC=0xFFFF, zero-wait memory → fetches 0xFFFF then 0x0000.
- With `FETCH_PERF_EN`: 10 fetches and 2 redirect cycles → `perf_fetched`=10 and `perf_flushed`=2; both are 0 after `reset`.
